// File: rtl/clkdiv_mon_pkg.sv
// Shared types and constants for the clock-divider tap monitor.
package clkdiv_mon_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      INIT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } tap_state_t;

   // Nominal half-period of tap idx, in clk cycles.
   function automatic int exp_half(input int idx);
      return 1 << idx;
   endfunction

   // Run length (no edge seen) at which a tap is declared stalled.
   function automatic int timeout_half(input int idx);
      return 2 * exp_half(idx) + 1;
   endfunction

endpackage

// File: rtl/clkdiv_tap_checker.sv
// One tap's half-period checker: run counter, lock FSM, sticky error and
// last measured half-period.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   INIT   | no reference edge yet; the next edge starts a measurement
//   SYNC   | measuring, fewer than LOCK_EDGES consecutive good halves
//   LOCKED | LOCK_EDGES consecutive good halves seen, still measuring
module clkdiv_tap_checker
   import clkdiv_mon_pkg::*;
#(
   parameter int TAP_IDX    = 0,
   parameter int LOCK_EDGES = 4,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tap,
   input  logic             tap_q,
   input  logic             clear,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] last_half
);

   localparam int GOOD_W = (LOCK_EDGES < 1) ? 1 : $clog2(LOCK_EDGES + 1);

   localparam logic [CNT_W-1:0]  EXP_RUN  = CNT_W'(exp_half(TAP_IDX));
   localparam logic [CNT_W-1:0]  TO_RUN   = CNT_W'(timeout_half(TAP_IDX));
   localparam logic [CNT_W-1:0]  RUN_MAX  = '1;
   localparam logic [GOOD_W-1:0] GOOD_MAX = '1;
   localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_EDGES);

   tap_state_t        state;
   logic [CNT_W-1:0]  run_cnt;
   logic [GOOD_W-1:0] good_cnt;
   logic [GOOD_W-1:0] good_inc;
   logic              tap_edge;
   logic              run_eq_exp;
   logic              run_timeout;
   logic              err_set;

   // Edge detect, compare results and the error-set condition for this cycle.
   always_comb begin
      tap_edge    = tap ^ tap_q;
      run_eq_exp  = (run_cnt == EXP_RUN);
      run_timeout = (run_cnt == TO_RUN);
      good_inc    = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
      err_set     = 1'b0;
      if (state != INIT) begin
         err_set = tap_edge ? !run_eq_exp : run_timeout;
      end
   end

   // Cycles since the last edge: restarts at 1 after an edge, saturates.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt <= '0;
      end else if (tap_edge) begin
         run_cnt <= CNT_W'(1);
      end else if (run_cnt != RUN_MAX) begin
         run_cnt <= run_cnt + 1'b1;
      end
   end

   // Lock FSM with registered locked/last_half and the sticky error bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         good_cnt  <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
         last_half <= '0;
      end else begin
         // a new error wins over a simultaneous clear
         err <= err_set | (err & ~clear);
         case (state)
            INIT: begin
               // first half-period after INIT is partial, so it is not judged
               if (tap_edge) begin
                  state    <= SYNC;
                  good_cnt <= '0;
               end
            end
            SYNC, LOCKED: begin
               if (tap_edge) begin
                  last_half <= run_cnt;
                  if (run_eq_exp) begin
                     good_cnt <= good_inc;
                     if (state == SYNC && good_inc >= LOCK_CNT) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     good_cnt <= '0;
                     state    <= SYNC;
                     locked   <= 1'b0;
                  end
               end else if (run_timeout) begin
                  // stalled tap: drop back to INIT so the timeout fires once
                  good_cnt <= '0;
                  state    <= INIT;
                  locked   <= 1'b0;
               end
            end
            default: begin
               good_cnt <= '0;
               state    <= INIT;
               locked   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/clkdiv_monitor.sv
// Clock-divider tap bus monitor: samples the divider taps as data in the clk
// domain and checks every half-period of every tap against its nominal ratio.
module clkdiv_monitor
   import clkdiv_mon_pkg::*;
#(
   parameter int NTAPS      = 4,
   parameter int LOCK_EDGES = 4,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NTAPS-1:0]       taps,
   input  logic                   clear,
   output logic [NTAPS-1:0]       locked,
   output logic [NTAPS-1:0]       err,
   output logic                   err_any,
   output logic [NTAPS*CNT_W-1:0] last_half
);

   logic [NTAPS-1:0] taps_q;

   // Single register stage on the tap bus; edges are taps != taps_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         taps_q <= '0;
      end else begin
         taps_q <= taps;
      end
   end

   // Summary error flag straight off the registered sticky bits.
   always_comb begin
      err_any = |err;
   end

   for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
      clkdiv_tap_checker #(
         .TAP_IDX    (gi),
         .LOCK_EDGES (LOCK_EDGES),
         .CNT_W      (CNT_W)
      ) u_chk (
         .clk       (clk),
         .rst       (rst),
         .tap       (taps[gi]),
         .tap_q     (taps_q[gi]),
         .clear     (clear),
         .locked    (locked[gi]),
         .err       (err[gi]),
         .last_half (last_half[gi*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_clkdiv_monitor.sv
// Bench for clkdiv_monitor: a free-running binary divider with injectable
// faults drives the taps; a timestamp-based reference model predicts outputs.
module tb_clkdiv_monitor;

   localparam int NTAPS      = 4;
   localparam int LOCK_EDGES = 4;
   localparam int CNT_W      = 8;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   clear = 1'b0;
   logic [NTAPS-1:0]       taps = '0;
   logic [NTAPS-1:0]       locked;
   logic [NTAPS-1:0]       err;
   logic                   err_any;
   logic [NTAPS*CNT_W-1:0] last_half;

   clkdiv_monitor #(
      .NTAPS      (NTAPS),
      .LOCK_EDGES (LOCK_EDGES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .taps      (taps),
      .clear     (clear),
      .locked    (locked),
      .err       (err),
      .err_any   (err_any),
      .last_half (last_half)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // divider and fault injection
   logic [15:0]      div_cnt     = '0;
   bit               div_run     = 1'b0;
   bit               tap0_div4   = 1'b0;
   logic [NTAPS-1:0] hold_mask   = '0;
   logic [NTAPS-1:0] hold_val    = '0;
   logic [NTAPS-1:0] xor_mask    = '0;
   logic [NTAPS-1:0] glitch_mask = '0;

   // reference model: tracks time of last edge per tap, not a run counter
   int               cyc = 0;
   logic [NTAPS-1:0] m_prev = '0;
   bit               m_ref    [NTAPS];
   int               m_streak [NTAPS];
   int               m_le     [NTAPS];
   logic [NTAPS-1:0]       exp_err    = '0;
   logic [NTAPS-1:0]       exp_locked = '0;
   logic [NTAPS*CNT_W-1:0] exp_last   = '0;

   task automatic model_step();
      int  half;
      int  e;
      bit  set;
      bit  edg;
      cyc++;
      if (rst) begin
         m_prev     = '0;
         exp_err    = '0;
         exp_locked = '0;
         exp_last   = '0;
         for (int i = 0; i < NTAPS; i++) begin
            m_ref[i]    = 1'b0;
            m_streak[i] = 0;
            m_le[i]     = cyc + 1;
         end
      end else begin
         for (int i = 0; i < NTAPS; i++) begin
            e    = 1 << i;
            half = cyc - m_le[i];
            edg  = (taps[i] != m_prev[i]);
            set  = 1'b0;
            if (edg) begin
               if (m_ref[i]) begin
                  exp_last[i*CNT_W +: CNT_W] = CNT_W'(half);
                  if (half == e) begin
                     m_streak[i]++;
                  end else begin
                     set         = 1'b1;
                     m_streak[i] = 0;
                  end
               end else begin
                  m_ref[i]    = 1'b1;
                  m_streak[i] = 0;
               end
               m_le[i] = cyc;
            end else if (m_ref[i] && half == 2 * e + 1) begin
               set         = 1'b1;
               m_ref[i]    = 1'b0;
               m_streak[i] = 0;
            end
            exp_err[i]    = set | (exp_err[i] & ~clear);
            exp_locked[i] = m_ref[i] && (m_streak[i] >= LOCK_EDGES);
         end
         m_prev = taps;
      end
   endtask

   // one clock: model sees the same inputs as the DUT, then drive next inputs
   task automatic tick();
      logic [NTAPS-1:0] raw;
      @(posedge clk);
      model_step();
      #1;
      if (div_run) div_cnt++;
      raw = div_cnt[NTAPS-1:0];
      if (tap0_div4) raw[0] = div_cnt[1];
      raw  = raw ^ xor_mask ^ glitch_mask;
      taps = (raw & ~hold_mask) | (hold_val & hold_mask);
      glitch_mask = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      div_run = 1'b0;
      div_cnt = '0;
      repeat (3) tick();
      n_tests++;
      if (locked !== '0) begin n_fail++; $display("FAIL reset_locked: got %b want 0000", locked); end
      n_tests++;
      if (err !== '0) begin n_fail++; $display("FAIL reset_err: got %b want 0000", err); end
      n_tests++;
      if (err_any !== 1'b0) begin n_fail++; $display("FAIL reset_err_any: got %b want 0", err_any); end
      n_tests++;
      if (last_half !== '0) begin n_fail++; $display("FAIL reset_last_half: got %h want 0", last_half); end
      rst = 1'b0;
      div_run = 1'b1;
   endtask

   task automatic test_lock();
      for (int c = 0; c < 42; c++) begin
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_lock: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
      end
      n_tests++;
      if (locked !== 4'hF) begin n_fail++; $display("FAIL lock_by_42: got %b want 1111", locked); end
      n_tests++;
      if (err !== '0) begin n_fail++; $display("FAIL lock_err: got %b want 0000", err); end
      n_tests++;
      if (last_half !== 32'h08040201) begin n_fail++; $display("FAIL lock_last_half: got %h want 08040201", last_half); end
   endtask

   task automatic test_hold();
      hold_val  = taps;
      hold_mask = 4'b0100;
      for (int c = 0; c < 12; c++) begin
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_hold: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
      end
      n_tests++;
      if ({err[2], locked[2], err_any} !== 3'b101) begin
         n_fail++; $display("FAIL hold_timeout: got err2=%b lock2=%b any=%b want 1 0 1", err[2], locked[2], err_any);
      end
      n_tests++;
      if (locked[1:0] !== 2'b11 || locked[3] !== 1'b1) begin
         n_fail++; $display("FAIL hold_others: got %b want 1x11", locked);
      end
      hold_mask = '0;
      for (int c = 0; c < 45; c++) begin
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_hold_resume: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
      end
      n_tests++;
      if (locked !== 4'hF || err[2] !== 1'b1) begin
         n_fail++; $display("FAIL hold_relock: got lock=%b err=%b want 1111 x1xx", locked, err);
      end
   endtask

   task automatic test_glitch();
      for (int k = 0; k < 8 && div_cnt[2:0] != 3'd2; k++) tick();
      glitch_mask = 4'b1000;
      tick();
      tick();
      n_tests++;
      if (last_half[31:24] !== 8'd3) begin n_fail++; $display("FAIL glitch_last_half: got %0d want 3", last_half[31:24]); end
      n_tests++;
      if ({err[3], locked[3]} !== 2'b10) begin
         n_fail++; $display("FAIL glitch_flags: got err3=%b lock3=%b want 1 0", err[3], locked[3]);
      end
      for (int c = 0; c < 45; c++) begin
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_glitch: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
      end
      n_tests++;
      if ({locked[3], err[3]} !== 2'b11) begin
         n_fail++; $display("FAIL glitch_relock: got lock3=%b err3=%b want 1 1", locked[3], err[3]);
      end
   endtask

   task automatic test_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_tests++;
      if ({err, err_any} !== 5'b0) begin n_fail++; $display("FAIL clear_err: got %b any=%b want 0000 0", err, err_any); end
      // phase-invert tap 0: one missing edge, then a 2-cycle half with clear
      xor_mask[0] = 1'b1;
      tick();
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      n_tests++;
      if (err[0] !== 1'b1) begin n_fail++; $display("FAIL clear_vs_set: got err0=%b want 1", err[0]); end
      n_tests++;
      if (last_half[7:0] !== 8'd2) begin n_fail++; $display("FAIL clear_vs_set_half: got %0d want 2", last_half[7:0]); end
      n_tests++;
      if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
         n_fail++;
         $display("FAIL model_clear: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                  locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
      end
   endtask

   task automatic test_reset_mid();
      xor_mask[1] = ~xor_mask[1];
      for (int c = 0; c < 30; c++) begin
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_pre_reset: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
      end
      n_tests++;
      if (locked !== 4'hF || err[1] !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_state: got lock=%b err=%b want 1111 xx1x", locked, err);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if ({locked, err, last_half} !== '0) begin
         n_fail++; $display("FAIL mid_reset: got lock=%b err=%b half=%h want all 0", locked, err, last_half);
      end
      for (int c = 0; c < 42; c++) begin
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_post_reset: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
      end
      n_tests++;
      if (locked !== 4'hF) begin n_fail++; $display("FAIL relock_after_reset: got %b want 1111", locked); end
   endtask

   task automatic test_div4();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tap0_div4 = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_div4: got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
         if (c >= 6) begin
            n_tests++;
            if (locked[0] !== 1'b0) begin n_fail++; $display("FAIL div4_locked: got %b want 0", locked[0]); end
         end
      end
      n_tests++;
      if ({err[0], last_half[7:0]} !== {1'b1, 8'd2}) begin
         n_fail++; $display("FAIL div4_result: got err0=%b half0=%0d want 1 2", err[0], last_half[7:0]);
      end
      tap0_div4 = 1'b0;
   endtask

   task automatic test_random();
      int hold_left = 0;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 32) == 0) glitch_mask[$urandom_range(0, NTAPS-1)] = 1'b1;
         if (hold_left == 0 && $urandom_range(0, 49) == 0) begin
            hold_val  = taps;
            hold_mask = '0;
            hold_mask[$urandom_range(0, NTAPS-1)] = 1'b1;
            hold_left = $urandom_range(1, 20);
         end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) hold_mask = '0;
         end
         clear = ($urandom_range(0, 49) == 0);
         rst   = ($urandom_range(0, 299) == 0);
         tick();
         n_tests++;
         if ({locked, err, err_any, last_half} !== {exp_locked, exp_err, |exp_err, exp_last}) begin
            n_fail++;
            $display("FAIL model_random: cyc=%0d got l=%b e=%b a=%b h=%h want l=%b e=%b a=%b h=%h",
                     cyc, locked, err, err_any, last_half, exp_locked, exp_err, |exp_err, exp_last);
         end
      end
      clear     = 1'b0;
      rst       = 1'b0;
      hold_mask = '0;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_hold();
      test_glitch();
      test_clear();
      test_reset_mid();
      test_div4();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule

// File: doc/clkdiv_monitor.md
# clkdiv_monitor

Checker for the clock divider's tap bus. It samples the divided-clock taps as ordinary data in the `clk` domain and measures every half-period, cycle-accurately, against the expected divide ratio. For each tap it reports lock, sticky error and the last measured half-period. It sits beside the divider at the receiving end of its `count` bus and gives the system a built-in health check of the divider chain.

## Interface
- `NTAPS`, default 4: number of taps; tap i nominally divides `clk` by 2^(i+1).
- `LOCK_EDGES`, default 4: consecutive correct half-periods needed to declare lock.
- `CNT_W`, default 8: width of the run counter and of each measured half-period; must hold 2^NTAPS + 1.
- `clk`  in  1: single clock; everything is synchronous to its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `taps`  in  NTAPS: divider outputs; bit 0 is divide-by-2 and bit NTAPS-1 is the slowest.
- `clear`  in  1: one-cycle pulse that clears all sticky `err` bits.
- `locked`  out  NTAPS: tap i has had `LOCK_EDGES` consecutive correct half-periods.
- `err`  out  NTAPS: sticky; tap i had a wrong half-period or a timeout.
- `err_any`  out  1: OR of `err`.
- `last_half`  out  NTAPS*CNT_W: field i holds tap i's last measured half-period in `clk` cycles.

## Operation
- Expected half-period for tap i: EXP(i) = 2^i cycles (1, 2, 4, 8 for the default).
- `taps` is registered once into `taps_q`. Edge on tap i means `taps[i] != taps_q[i]` in that cycle.
- Run counter per tap:
  - Loads 1 in the cycle after an edge, otherwise increments.
  - Saturates at all-ones.
  - Its value in an edge cycle equals the number of cycles since the previous edge.
- Per-tap FSM with states INIT, SYNC and LOCKED:
  - INIT, on edge: go to SYNC, no check (the first half-period is partial), good count = 0.
  - SYNC or LOCKED, on edge with run == EXP(i): `last_half` = run, good count +1 (saturating). In SYNC, reaching `LOCK_EDGES` moves the tap to LOCKED.
  - SYNC or LOCKED, on edge with run != EXP(i): `last_half` = run, `err[i]` set, good count = 0, go to SYNC.
  - SYNC or LOCKED, no edge and run == 2·EXP(i)+1 (timeout): `err[i]` set, good count = 0, go to INIT. The timeout fires once, not every cycle.
- `locked[i]` is 1 exactly when the tap is in LOCKED.
- `clear` and an error setting in the same cycle: the set wins, so `err[i]` stays 1. `clear` does not affect state, `locked` or `last_half`.
- Taps are fully independent. No cross-tap phase check in this revision.

## Timing
- Reset values (cycle after `rst` is high): `locked` = 0, `err` = 0, `err_any` = 0, `last_half` = 0, all FSMs INIT, run counters 0, `taps_q` = 0.
- Reset mid-operation discards all history. The first edge after reset is unchecked.
- Output latency:
  - `locked`, `err` and `last_half` update in the cycle after the edge or timeout cycle that caused the change (registered).
  - `err_any` is combinational from registered `err`, so it has the same latency.
- A `taps` value held high through reset: the first sample after reset sees `taps_q` = 0, so an edge is flagged. This is harmless because INIT does not check it.
- Lock bound for a correct divider: tap NTAPS-1 locks no later than 2^(NTAPS-1)·(LOCK_EDGES+1)+2 cycles after reset release, which is 42 cycles for the defaults.

## Structure
- Package `clkdiv_mon_pkg`:
  - state enum {INIT, SYNC, LOCKED};
  - function `exp_half(i)` returning 2^i;
  - `CNT_W` default;
  - timeout constant expressed as 2·exp_half+1.
- Sub-module `clkdiv_tap_checker`:
  - one tap's run counter, FSM, good count, sticky error and `last_half` register;
  - parameter `TAP_IDX`;
  - instanced NTAPS times in a generate loop.
- The top level holds only `taps_q`, the `clear` fan-out and the `err_any` OR.

## Test plan
- Divider `clockdivider` drives `taps`, `rst` released at cycle 0 → all `locked` = 1 by cycle 42, `err` = 0, `last_half` fields = {8, 4, 2, 1} from tap 3 down to tap 0.
- After lock, tap 2 held constant for 9 cycles → `err[2]` = 1, `locked[2]` = 0, `err_any` = 1; the other taps stay locked. When tap 2 resumes, it relocks after its first unchecked edge plus 4 good edges.
- After lock, one-cycle glitch on tap 3 → `last_half[3]` = the shortened count (for example 3), `err[3]` = 1, `locked[3]` = 0. Tap 3 relocks 4 good edges later while `err[3]` stays 1.
- `clear` pulsed with no faults → `err` = 0 the next cycle. `clear` in the same cycle as a tap 0 mismatch edge → `err[0]` = 1.
- `rst` asserted for 1 cycle while all taps are locked with `err[1]` = 1 → the next cycle shows `locked` = 0, `err` = 0, `last_half` = 0, and lock is regained within 42 cycles.
- Tap 0 driven as divide-by-4 (half-period 2) → `err[0]` = 1, `last_half[0]` = 2, `locked[0]` never 1.
